// File: rtl/mem_resp.sv
// mem_resp: byte-addressed RAM behind one write port and R_PORT read ports.
// One access is in flight at a time. Writes take priority; reads are
// arbitrated round-robin. The acknowledge arrives LATENCY cycles after the
// grant. A separate preload port writes single bytes at any time.
module mem_resp #(
  parameter int R_PORT  = 2,
  parameter int ADDR_B  = 16,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [R_PORT-1:0]     mem_re,
  input  logic [R_PORT*32-1:0]  mem_raddr,
  input  logic [R_PORT*2-1:0]   mem_rlen,
  output logic [R_PORT*32-1:0]  mem_dout,
  output logic [R_PORT-1:0]     mem_rack,
  input  logic                  mem_we,
  input  logic [31:0]           mem_waddr,
  input  logic [1:0]            mem_wlen,
  input  logic [31:0]           mem_din,
  output logic                  mem_wack,
  input  logic                  ld_we,
  input  logic [ADDR_B-1:0]     ld_addr,
  input  logic [7:0]            ld_data
);
  localparam int PW     = (R_PORT > 1) ? $clog2(R_PORT) : 1;
  localparam int CW     = $clog2(LATENCY + 1);
  localparam int LAT_M2 = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  state_t state, state_nx;

  logic [CW-1:0]     cnt;
  logic [PW-1:0]     ptr;
  logic              l_wr;
  logic [PW-1:0]     l_port;
  logic [ADDR_B-1:0] l_addr;
  logic [1:0]        l_len;
  logic [31:0]       l_data;

  logic [7:0]  ram [0:(2**ADDR_B)-1];
  logic [31:0] raddr_a [R_PORT];
  logic [1:0]  rlen_a  [R_PORT];
  logic [31:0] dout_r  [R_PORT];

  // Upper address bits carry no meaning for a 2^ADDR_B byte RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_waddr, mem_raddr};

  for (genvar i = 0; i < R_PORT; i++) begin : g_port
    assign raddr_a[i]          = mem_raddr[i*32 +: 32];
    assign rlen_a[i]           = mem_rlen[i*2 +: 2];
    assign mem_dout[i*32 +: 32] = dout_r[i];
  end

  // Round-robin search for the first requesting read port starting at ptr.
  logic          g_rd;
  logic [PW-1:0] g_port_sel;
  int            idx;
  always_comb begin
    g_rd       = 1'b0;
    g_port_sel = '0;
    idx        = 0;
    for (int k = 0; k < R_PORT; k++) begin
      idx = (int'(ptr) + k) % R_PORT;
      if (!g_rd && mem_re[idx[PW-1:0]]) begin
        g_rd       = 1'b1;
        g_port_sel = idx[PW-1:0];
      end
    end
  end

  logic grant, to_ack;
  assign grant  = (state == IDLE) && (mem_we || g_rd);
  assign to_ack = (grant && (LATENCY == 1)) || ((state == BUSY) && (cnt == '0));

  // Current access: live request inputs while idle, latched copy afterwards.
  // This lets a LATENCY=1 access commit on its grant edge.
  logic              acc_wr;
  logic [PW-1:0]     acc_port;
  logic [ADDR_B-1:0] acc_addr;
  logic [1:0]        acc_len;
  logic [31:0]       acc_data;
  always_comb begin
    acc_wr   = l_wr;
    acc_port = l_port;
    acc_addr = l_addr;
    acc_len  = l_len;
    acc_data = l_data;
    if (state == IDLE) begin
      acc_wr   = mem_we;
      acc_port = g_port_sel;
      acc_data = mem_din;
      acc_addr = mem_we ? mem_waddr[ADDR_B-1:0] : raddr_a[g_port_sel][ADDR_B-1:0];
      acc_len  = mem_we ? mem_wlen : rlen_a[g_port_sel];
    end
  end

  // Byte enables: len 0 -> 1 byte, 1 -> 2 bytes, 2/3 -> 4 bytes.
  logic [3:0]  be;
  logic [31:0] rd_data;
  assign be = {acc_len[1], acc_len[1], acc_len != 2'd0, 1'b1};
  for (genvar k = 0; k < 4; k++) begin : g_rd_byte
    assign rd_data[8*k +: 8] = be[k] ? ram[acc_addr + ADDR_B'(k)] : 8'h00;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = (LATENCY == 1) ? ACK : BUSY;
      BUSY:    if (cnt == '0) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, counter, pointer, latched access and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      l_wr     <= 1'b0;
      l_port   <= '0;
      l_addr   <= '0;
      l_len    <= '0;
      l_data   <= '0;
      mem_rack <= '0;
      mem_wack <= 1'b0;
      for (int i = 0; i < R_PORT; i++) dout_r[i] <= '0;
    end else begin
      state    <= state_nx;
      mem_rack <= '0;
      mem_wack <= 1'b0;
      if (grant) begin
        cnt    <= CW'(LAT_M2);
        l_wr   <= acc_wr;
        l_port <= acc_port;
        l_addr <= acc_addr;
        l_len  <= acc_len;
        l_data <= acc_data;
        if (!mem_we)
          ptr <= (g_port_sel == PW'(R_PORT-1)) ? '0 : g_port_sel + 1'b1;
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (to_ack) begin
        if (acc_wr) mem_wack <= 1'b1;
        else begin
          mem_rack[acc_port] <= 1'b1;
          dout_r[acc_port]   <= rd_data;
        end
      end
    end
  end

  // RAM: preload first so a same-edge core write to the same byte wins.
  always_ff @(posedge clk) begin
    if (ld_we) ram[ld_addr] <= ld_data;
    if (!rst && to_ack && acc_wr)
      for (int k = 0; k < 4; k++)
        if (be[k]) ram[acc_addr + ADDR_B'(k)] <= acc_data[8*k +: 8];
  end
endmodule

// File: tb/tb_mem_resp.sv
// Testbench for mem_resp: directed vector table, hand-written corner
// sequences and randomized single accesses against a byte-array model.
module tb_mem_resp;
  localparam int RP = 2, AB = 16, LAT = 2;

  logic              clk = 1'b0, rst;
  logic [RP-1:0]     mem_re;
  logic [RP*32-1:0]  mem_raddr;
  logic [RP*2-1:0]   mem_rlen;
  logic [RP*32-1:0]  mem_dout;
  logic [RP-1:0]     mem_rack;
  logic              mem_we, mem_wack;
  logic [31:0]       mem_waddr, mem_din;
  logic [1:0]        mem_wlen;
  logic              ld_we;
  logic [AB-1:0]     ld_addr;
  logic [7:0]        ld_data;

  always #5 clk = ~clk;

  mem_resp #(.R_PORT(RP), .ADDR_B(AB), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_re(mem_re), .mem_raddr(mem_raddr),
    .mem_rlen(mem_rlen), .mem_dout(mem_dout), .mem_rack(mem_rack),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wlen(mem_wlen),
    .mem_din(mem_din), .mem_wack(mem_wack), .ld_we(ld_we),
    .ld_addr(ld_addr), .ld_data(ld_data));

  int total = 0, bad = 0;
  logic [7:0]  mdl [0:65535];
  logic [31:0] exp_dout [RP];

  typedef struct {
    bit          wr;
    int          port;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [1:0] len);
    logic [31:0] r = 0;
    for (int k = 0; k < nbytes(len); k++) r[8*k +: 8] = mdl[a[15:0] + 16'(k)];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [1:0] len, input logic [31:0] d);
    for (int k = 0; k < nbytes(len); k++) mdl[a[15:0] + 16'(k)] = d[8*k +: 8];
  endtask

  function automatic logic [31:0] dout_of(input int p);
    return mem_dout[p*32 +: 32];
  endfunction

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_we = 1'b0;
    mdl[a] = d;
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, " rack"}, 32'(mem_rack), 0);
    check({nm, " wack"}, 32'(mem_wack), 0);
    for (int p = 0; p < RP; p++) check($sformatf("%s dout%0d", nm, p), dout_of(p), 0);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    for (int p = 0; p < RP; p++) exp_dout[p] = 0;
  endtask

  // One access issued from IDLE in cycle 0; optional preload driven in cycle ld_cyc.
  task automatic do_access(input bit wr, input int port, input logic [31:0] a,
                           input logic [1:0] len, input logic [31:0] wd,
                           input logic [31:0] exp, input int ld_cyc,
                           input logic [15:0] la, input logic [7:0] ld, input string nm);
    int got = -1;
    int c = 0;
    logic tgt;
    int others;
    @(negedge clk);
    if (wr) begin mem_we = 1'b1; mem_waddr = a; mem_wlen = len; mem_din = wd; end
    else begin mem_re[port] = 1'b1; mem_raddr[port*32 +: 32] = a; mem_rlen[port*2 +: 2] = len; end
    if (ld_cyc == 0) begin ld_we = 1'b1; ld_addr = la; ld_data = ld; end
    while (c <= LAT + 4 && (got < 0 || c == got)) begin
      @(posedge clk); @(negedge clk); c++;
      ld_we = 1'b0;
      if (c == 1) begin
        mem_we = 1'b0; mem_re = '0;
        mem_waddr = $urandom(); mem_din = $urandom(); mem_wlen = 2'($urandom());
        for (int p = 0; p < RP; p++) mem_raddr[p*32 +: 32] = $urandom();
        mem_rlen = RP*2'($urandom());
      end
      if (ld_cyc == c) begin ld_we = 1'b1; ld_addr = la; ld_data = ld; end
      tgt = wr ? mem_wack : mem_rack[port];
      others = $countones({mem_wack, mem_rack}) - (tgt ? 1 : 0);
      check({nm, " other acks"}, others, 0);
      if (got >= 0) check({nm, " pulse width"}, 32'(tgt), 0);
      else if (tgt) begin
        got = c;
        if (!wr) begin
          check({nm, " rdata"}, dout_of(port), exp);
          exp_dout[port] = exp;
        end
        for (int q = 0; q < RP; q++)
          if (wr || q != port) check($sformatf("%s hold%0d", nm, q), dout_of(q), exp_dout[q]);
      end
    end
    check({nm, " ack cycle"}, got, LAT);
    if (ld_cyc >= 0 && ld_cyc < LAT) mdl[la] = ld;
    if (wr) model_write(a, len, wd);
    if (ld_cyc >= LAT) mdl[la] = ld;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[$];
    int n;
    logic [31:0] r, a, exp;
    bit wr;
    int port, ldc;
    logic [15:0] la;

    mem_re = '0; mem_raddr = '0; mem_rlen = '0;
    mem_we = 1'b0; mem_waddr = '0; mem_wlen = '0; mem_din = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    for (int p = 0; p < RP; p++) exp_dout[p] = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Preload while reset is held.
    preload(16'h0100, 8'h11); preload(16'h0101, 8'h22);
    preload(16'h0102, 8'h33); preload(16'h0103, 8'h44);
    preload(16'h0006, 8'h66); preload(16'h0009, 8'h00);
    preload(16'hFFFF, 8'hF1); preload(16'h0000, 8'hA0);
    preload(16'h0001, 8'hA1); preload(16'h0002, 8'hA2);
    preload(16'h0300, 8'h04); preload(16'h0301, 8'h03);
    preload(16'h0302, 8'h02); preload(16'h0303, 8'h01);
    preload(16'h0400, 8'h77); preload(16'h0410, 8'h11);
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    tbl[0]  = '{0, 0, 32'h0000_0100, 2'd2, 32'h0,         32'h4433_2211};
    tbl[1]  = '{0, 1, 32'h0000_0100, 2'd0, 32'h0,         32'h0000_0011};
    tbl[2]  = '{0, 0, 32'h0000_0101, 2'd1, 32'h0,         32'h0000_3322};
    tbl[3]  = '{1, 0, 32'h0000_0007, 2'd1, 32'hAABB_CCDD, 32'h0};
    tbl[4]  = '{0, 1, 32'h0000_0006, 2'd2, 32'h0,         32'h00CC_DD66};
    tbl[5]  = '{0, 0, 32'h0000_0009, 2'd0, 32'h0,         32'h0000_0000};
    tbl[6]  = '{0, 1, 32'h0000_FFFF, 2'd2, 32'h0,         32'hA2A1_A0F1};
    tbl[7]  = '{0, 0, 32'h0010_FFFF, 2'd3, 32'h0,         32'hA2A1_A0F1};
    tbl[8]  = '{1, 0, 32'h0000_FFFE, 2'd2, 32'h1234_5678, 32'h0};
    tbl[9]  = '{0, 1, 32'h0000_0000, 2'd1, 32'h0,         32'h0000_1234};
    tbl[10] = '{0, 0, 32'hFF00_FFFE, 2'd2, 32'h0,         32'h1234_5678};
    for (int i = 0; i < 11; i++)
      do_access(tbl[i].wr, tbl[i].port, tbl[i].addr, tbl[i].len, tbl[i].wdata,
                tbl[i].exp, -1, 16'h0, 8'h0, $sformatf("vec%0d", i));

    // Preload on the read-sample edge: read sees old byte, later read sees new.
    do_access(0, 0, 32'h400, 2'd0, 0, 32'h77, LAT-1, 16'h0400, 8'h88, "ld_rd same edge");
    do_access(0, 1, 32'h400, 2'd0, 0, 32'h88, -1, 16'h0, 8'h0, "ld_rd after");
    // Preload and core write to one byte on one edge: core write wins.
    do_access(1, 0, 32'h410, 2'd0, 32'h5A, 0, LAT-1, 16'h0410, 8'h99, "ld_wr same edge");
    do_access(0, 0, 32'h410, 2'd0, 0, 32'h5A, -1, 16'h0, 8'h0, "ld_wr after");

    // Reset during BUSY of a write aborts it.
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = 32'h300; mem_wlen = 2'd2; mem_din = 32'h55AA_55AA;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; mem_we = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("abort");
    rst = 1'b0;
    for (int p = 0; p < RP; p++) exp_dout[p] = 0;
    n = 0;
    repeat (5) begin @(negedge clk); n += int'(mem_wack); end
    check("abort no wack", n, 0);
    do_access(0, 0, 32'h300, 2'd2, 0, 32'h0102_0304, -1, 16'h0, 8'h0, "abort ram");

    // Write and both reads together: write, port 0, port 1.
    do_reset();
    @(negedge clk);
    mem_we = 1'b1; mem_waddr = 32'h200; mem_wlen = 2'd2; mem_din = 32'hDEAD_BEEF;
    mem_re = '1;
    mem_raddr[31:0] = 32'h200; mem_rlen[1:0] = 2'd2;
    mem_raddr[63:32] = 32'h100; mem_rlen[3:2] = 2'd2;
    order = {};
    repeat (30) begin
      @(posedge clk); @(negedge clk);
      check("arb overlap", 32'($countones({mem_wack, mem_rack}) > 1), 0);
      if (mem_wack) begin order.push_back(2); mem_we = 1'b0; end
      if (mem_rack[0]) begin
        order.push_back(0); mem_re[0] = 1'b0;
        check("arb dout0", dout_of(0), 32'hDEAD_BEEF);
      end
      if (mem_rack[1]) begin
        order.push_back(1); mem_re[1] = 1'b0;
        check("arb dout1", dout_of(1), 32'h4433_2211);
      end
    end
    mem_we = 1'b0; mem_re = '0;
    model_write(32'h200, 2'd2, 32'hDEAD_BEEF);
    check("arb count", order.size(), 3);
    if (order.size() == 3) begin
      check("arb first", order[0], 2);
      check("arb second", order[1], 0);
      check("arb third", order[2], 1);
    end

    // Both reads held: grants alternate starting at port 0.
    do_reset();
    @(negedge clk);
    mem_raddr[31:0] = 32'h100; mem_rlen[1:0] = 2'd0;
    mem_raddr[63:32] = 32'h101; mem_rlen[3:2] = 2'd0;
    mem_re = '1;
    order = {};
    for (int c = 0; c < 60 && order.size() < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (mem_rack[0]) order.push_back(0);
      if (mem_rack[1]) order.push_back(1);
    end
    mem_re = '0;
    check("rr count", order.size(), 6);
    for (int i = 0; i < 6 && i < order.size(); i++)
      check($sformatf("rr grant%0d", i), order[i], i % 2);
    check("rr dout1", dout_of(1), 32'h22);
    exp_dout[0] = 32'h11; exp_dout[1] = 32'h22;
    repeat (3) @(negedge clk);

    // Randomized accesses against the model.
    for (int k = 0; k < 16; k++) begin
      preload(16'h0500 + 16'(k), 8'($urandom()));
      preload(16'hFFF0 + 16'(k), 8'($urandom()));
      preload(16'h0000 + 16'(k), 8'($urandom()));
    end
    for (int i = 0; i < 150; i++) begin
      wr = ($urandom_range(0, 2) == 0);
      port = $urandom_range(0, RP-1);
      r = $urandom();
      a = ($urandom_range(0, 3) == 0) ? {r[31:16], 16'hFFFC + 16'($urandom_range(0, 3))}
                                      : {r[31:16], 16'h0500 + 16'($urandom_range(0, 11))};
      la = 16'h0500 + 16'($urandom_range(0, 15));
      ldc = ($urandom_range(0, 3) == 0) ? $urandom_range(LAT-1, LAT) : -1;
      exp = model_read(a, r[1:0]);
      do_access(wr, port, a, r[1:0], $urandom(), exp, ldc, la, 8'($urandom()),
                $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
